// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative 16-bit shift-add multiplier / restoring divider
// One multiply or division step per clock; results are registered on entry to DONE.
module muldiv_unit #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       dest,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic [3:0]       wdest,
  output logic             dz
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [1:0] OP_UDIV = 2'b01;
  localparam logic [1:0] OP_UREM = 2'b10;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [3:0]       dest_q, dest_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] res_hi_q, res_hi_d;
  logic [3:0]       wdest_q, wdest_d;
  logic             dz_q, dz_d;

  logic             run_div;
  logic             start_div;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  assign run_div   = (op_q == OP_UDIV) || (op_q == OP_UREM);
  assign start_div = (op == OP_UDIV) || (op == OP_UREM);

  // hi holds the product upper half (MUL) or the partial remainder (DIV);
  // lo holds the multiplier (MUL) or the dividend shifting into the quotient (DIV).
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    if (run_div) begin
      step_hi = div_ge ? WIDTH'(div_shift - {1'b0, opnd_q}) : div_shift[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    dest_d   = dest_q;
    opnd_d   = opnd_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    res_d    = res_q;
    res_hi_d = res_hi_q;
    wdest_d  = wdest_q;
    dz_d     = dz_q;
    case (state_q)
      S_RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        hi_d  = step_hi;
        lo_d  = step_lo;
        if (cnt_q == CNT_W'(1)) begin
          state_d  = S_DONE;
          wdest_d  = dest_q;
          res_hi_d = step_hi;
          res_d    = (op_q == OP_UREM) ? step_hi : step_lo;
        end
      end
      default: begin
        state_d = S_IDLE;
        if (start) begin
          op_d   = op;
          dest_d = dest;
          dz_d   = 1'b0;
          cnt_d  = CNT_W'(WIDTH);
          hi_d   = '0;
          opnd_d = start_div ? b : a;
          lo_d   = start_div ? a : b;
          if (start_div && (b == '0)) begin
            state_d  = S_DONE;
            dz_d     = 1'b1;
            wdest_d  = dest;
            res_hi_d = a;
            res_d    = (op == OP_UREM) ? a : '1;
          end else begin
            state_d = S_RUN;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      dest_q   <= '0;
      opnd_q   <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      res_q    <= '0;
      res_hi_q <= '0;
      wdest_q  <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      dest_q   <= dest_d;
      opnd_q   <= opnd_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      res_q    <= res_d;
      res_hi_q <= res_hi_d;
      wdest_q  <= wdest_d;
      dz_q     <= dz_d;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign result    = res_q;
  assign result_hi = res_hi_q;
  assign wdest     = wdest_q;
  assign dz        = dz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed and random checks of muldiv_unit against an arithmetic model
module tb_muldiv_unit;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic [3:0]   dest;
  logic         busy, done, dz;
  logic [W-1:0] result, result_hi;
  logic [3:0]   wdest;

  int checks = 0;
  int errors = 0;

  muldiv_unit #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .dest(dest),
    .busy(busy), .done(done), .result(result), .result_hi(result_hi),
    .wdest(wdest), .dz(dz)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {dz, result_hi, result} from plain arithmetic.
  function automatic logic [32:0] model(input logic [1:0] o, input logic [15:0] x,
                                        input logic [15:0] y);
    logic [31:0] p;
    logic [15:0] q, r;
    if (o == 2'b01 || o == 2'b10) begin
      if (y == 16'd0) return {1'b1, x, (o == 2'b10) ? x : 16'hFFFF};
      q = x / y;
      r = x % y;
      return {1'b0, r, (o == 2'b10) ? r : q};
    end
    p = {16'd0, x} * {16'd0, y};
    return {1'b0, p};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                       input logic [3:0] d);
    op = o; a = x; b = y; dest = d; start = 1'b1;
    step();
    start = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    op = 2'($urandom);
    dest = 4'($urandom);
  endtask

  task automatic run_op(input string tag, input logic [1:0] o, input logic [15:0] x,
                        input logic [15:0] y, input logic [3:0] d);
    logic [32:0] e;
    int done_cyc, busy_n, cyc;
    e = model(o, x, y);
    done_cyc = -1;
    busy_n = 0;
    cyc = 1;
    issue(o, x, y, d);
    while (cyc <= 40) begin
      if (cyc == 1 && !e[32]) check({tag, "_dz_clr"}, 32'(dz), 0);
      if (busy) busy_n++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      step();
      cyc++;
    end
    check({tag, "_done_cyc"}, 32'(done_cyc), e[32] ? 1 : 17);
    check({tag, "_busy_n"}, 32'(busy_n), e[32] ? 0 : 16);
    check({tag, "_result"}, 32'(result), 32'(e[15:0]));
    check({tag, "_result_hi"}, 32'(result_hi), 32'(e[31:16]));
    check({tag, "_wdest"}, 32'(wdest), 32'(d));
    check({tag, "_dz"}, 32'(dz), 32'(e[32]));
    step();
    check({tag, "_done_low"}, 32'(done), 0);
    check({tag, "_hold"}, {result_hi, result}, e[31:0]);
  endtask

  initial begin
    int early;
    logic [1:0] ro;
    logic [15:0] rx, ry;
    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0; dest = '0;
    step(); step();
    rst = 1'b0;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_outs", {result_hi, result}, 0);
    check("rst_wdest_dz", {wdest, dz}, 0);

    run_op("mul_300_250", 2'b00, 16'd300, 16'd250, 4'd3);
    run_op("udiv_1000_7", 2'b01, 16'd1000, 16'd7, 4'd4);
    run_op("urem_1000_7", 2'b10, 16'd1000, 16'd7, 4'd5);
    run_op("mul_ffff_ffff", 2'b00, 16'hFFFF, 16'hFFFF, 4'd15);
    run_op("udiv_dz", 2'b01, 16'h1234, 16'd0, 4'd7);
    run_op("urem_after_dz", 2'b10, 16'd77, 16'd10, 4'd8);
    run_op("urem_dz", 2'b10, 16'hBEEF, 16'd0, 4'd1);
    run_op("mul_ffff_0", 2'b00, 16'hFFFF, 16'd0, 4'd2);
    run_op("udiv_5_9", 2'b01, 16'd5, 16'd9, 4'd6);
    run_op("udiv_8000_1", 2'b01, 16'h8000, 16'd1, 4'd9);
    run_op("op3_as_mul", 2'b11, 16'd1234, 16'd56, 4'd10);

    // Starts during RUN must be ignored; then back-to-back issue from DONE.
    issue(2'b00, 16'd3, 16'd5, 4'd2);
    early = 0;
    for (int c = 1; c < 17; c++) begin
      if (!busy || done) early++;
      if (c == 5 || c == 10) begin
        op = 2'b01; a = 16'd100; b = 16'd0; dest = 4'd9; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    check("ign_run_flags", 32'(early), 0);
    check("ign_done17", 32'(done), 1);
    check("ign_result", {result_hi, result}, 32'd15);
    check("ign_wdest", 32'(wdest), 2);
    issue(2'b01, 16'd9, 16'd2, 4'd5);
    check("b2b_busy18", {busy, done}, 32'b10);
    early = 0;
    for (int c = 18; c < 34; c++) begin
      if (done) early++;
      step();
    end
    check("b2b_no_early_done", 32'(early), 0);
    check("b2b_done34", 32'(done), 1);
    check("b2b_result", {result_hi, result}, {16'd1, 16'd4});
    check("b2b_wdest", 32'(wdest), 5);
    step();

    // Reset in cycle 8 of a division.
    issue(2'b01, 16'd1000, 16'd7, 4'd6);
    for (int c = 1; c < 8; c++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_flags", {busy, done, dz}, 0);
    check("abort_outs", {result_hi, result}, 0);
    check("abort_wdest", 32'(wdest), 0);
    early = 0;
    for (int c = 0; c < 30; c++) begin
      if (done || busy) early++;
      step();
    end
    check("abort_no_done", 32'(early), 0);
    run_op("after_abort", 2'b00, 16'd300, 16'd250, 4'd3);

    for (int i = 0; i < 40; i++) begin
      ro = 2'($urandom_range(0, 3));
      rx = 16'($urandom);
      case ($urandom_range(0, 5))
        0: ry = 16'd0;
        1: ry = 16'($urandom_range(1, 15));
        default: ry = 16'($urandom);
      endcase
      run_op("rand", ro, rx, ry, 4'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
